// File: rtl/mux_arb_n_to_1.sv
// Registered N:1 valid/ready multiplexer: round-robin (mode=0) or fixed-select (mode=1) arbitration.
// Optional macro MUX_ARB_XFER_CNT_EN adds a saturating 16-bit input-transfer counter (xfer_cnt).
module mux_arb_n_to_1 #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_ARB_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  if (N < 2 || N > 16 || (1 << SEL_W) < N) begin : g_param_check
    $fatal(1, "mux_arb_n_to_1: need 2 <= N <= 16 and 2**SEL_W >= N");
  end

  logic [N-1:0][W-1:0] lanes;
  logic [2*N-1:0]      rot;
  logic [SEL_W-1:0]    ptr, gnt;
  logic [W-1:0]        gnt_data;
  logic                gnt_vld, load_en, xfer;
  int                  sum;

  assign lanes   = in_data;
  assign load_en = !out_valid || out_ready;
  assign xfer    = !reset && load_en && gnt_vld;

  // Rotating by ptr puts the search order at bit 0; scanning downward leaves the first hit.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    sum      = 0;
    rot      = {in_valid, in_valid} >> ptr;
    if (mode) begin
      for (int i = 0; i < N; i++)
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(i);
        end
    end else begin
      for (int k = N - 1; k >= 0; k--)
        if (rot[k]) begin
          gnt_vld = 1'b1;
          sum     = int'(ptr) + k;
        end
      if (sum >= N) sum = sum - N;
      gnt = SEL_W'(sum);
    end
    for (int i = 0; i < N; i++)
      if (gnt == SEL_W'(i)) gnt_data = lanes[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign in_ready[i] = xfer && (gnt == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt;
      ptr       <= (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                          xfer_cnt <= '0;
    else if (xfer && xfer_cnt != '1)    xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule
